// File: rtl/reg_pkg.sv
// reg_pkg: shared widths, FIFO entry type and source encoding for the writeback path.
package reg_pkg;
    localparam int REG_ADDR_W    = 3;
    localparam int DATA_W        = 16;
    localparam int NUM_REGS      = 8;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int PTR_W         = $clog2(WB_FIFO_DEPTH);
    localparam int CNT_W         = $clog2(WB_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {SRC_MEM = 1'b0, SRC_ALU = 1'b1} src_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order result queue exposing head, occupancy and per-slot valid/destination.
module wb_fifo
    import reg_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       push,
    input  logic                                       pop,
    input  wb_entry_t                                  din,
    output wb_entry_t                                  head,
    output logic [CNT_W-1:0]                           count,
    output logic [WB_FIFO_DEPTH-1:0]                   ent_valid,
    output logic [WB_FIFO_DEPTH-1:0][REG_ADDR_W-1:0]   ent_reg
);
    wb_entry_t           mem_q [WB_FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < WB_FIFO_DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(i) - rptr_q;
        assign ent_valid[i] = {1'b0, off} < count_q;
        assign ent_reg[i]   = mem_q[i].rd;
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU and load results into a FIFO and drains it into the RegisterFile write port.
module reg_writeback
    import reg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_ADDR_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    wb_enable,
    output logic [REG_ADDR_W-1:0]   write_reg,
    output logic [DATA_W-1:0]       write_data,
    output logic                    reg_write,
    output logic [NUM_REGS-1:0]     pending,
    output logic [CNT_W-1:0]        fifo_count
);
    wb_entry_t                                 head, din;
    logic [WB_FIFO_DEPTH-1:0]                  ent_valid;
    logic [WB_FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  ent_reg;
    logic                                      full, conflict, alu_push, mem_push, push, pop;
    src_t                                      rr_q, rr_d;
    logic [REG_ADDR_W-1:0]                     write_reg_q, write_reg_d;
    logic [DATA_W-1:0]                         write_data_q, write_data_d;
    logic                                      reg_write_q, reg_write_d;

    wb_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .head      (head),
        .count     (fifo_count),
        .ent_valid (ent_valid),
        .ent_reg   (ent_reg)
    );

    // rr_q names the source that wins the next simultaneous offer.
    always_comb begin
        full         = fifo_count == CNT_W'(WB_FIFO_DEPTH);
        alu_ready    = !full && (!mem_valid || rr_q == SRC_ALU);
        mem_ready    = !full && (!alu_valid || rr_q == SRC_MEM);
        alu_push     = alu_valid && alu_ready;
        mem_push     = mem_valid && mem_ready;
        push         = alu_push || mem_push;
        pop          = wb_enable && fifo_count != '0;
        conflict     = alu_valid && mem_valid && !full;
        rr_d         = conflict ? (rr_q == SRC_ALU ? SRC_MEM : SRC_ALU) : rr_q;
        din          = alu_push ? {alu_reg, alu_data} : {mem_reg, mem_data};
        reg_write_d  = pop;
        write_reg_d  = pop ? head.rd : write_reg_q;
        write_data_d = pop ? head.data : write_data_q;
        pending      = '0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++)
            if (ent_valid[i]) pending[ent_reg[i]] = 1'b1;
        if (reg_write_q) pending[write_reg_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= SRC_MEM;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            rr_q         <= rr_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: drives reg_writeback into a RegisterFile and checks it against a queue-based model.
module tb_reg_writeback;
    import reg_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, wb_enable, reg_write;
    logic [2:0]  alu_reg, mem_reg, write_reg, raddr1;
    logic [15:0] alu_data, mem_data, write_data, read_data1;
    logic [7:0]  pending;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .wb_enable(wb_enable), .write_reg(write_reg), .write_data(write_data),
        .reg_write(reg_write), .pending(pending), .fifo_count(fifo_count)
    );

    logic [15:0] rf [8];
    always_ff @(posedge clk) if (reg_write) rf[write_reg] <= write_data;
    assign read_data1 = rf[raddr1];

    logic [18:0] q[$];
    logic        m_rw, m_alu_turn, g_alu, g_mem;
    logic [2:0]  m_wr;
    logic [15:0] m_wd;
    logic [15:0] m_rf [8];
    logic [7:0]  m_written;
    int          n_checks = 0, n_fail = 0;

    function automatic logic exp_alu_rdy();
        return q.size() < 4 && (!mem_valid || m_alu_turn);
    endfunction

    function automatic logic exp_mem_rdy();
        return q.size() < 4 && (!alu_valid || !m_alu_turn);
    endfunction

    function automatic logic [7:0] exp_pending();
        logic [7:0] p = '0;
        for (int i = 0; i < q.size(); i++) p[q[i][18:16]] = 1'b1;
        if (m_rw) p[m_wr] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rw = 0; m_wr = 0; m_wd = 0; m_alu_turn = 0; g_alu = 0; g_mem = 0;
    endtask

    task automatic tick();
        logic a, m, c;
        a = alu_valid && exp_alu_rdy();
        m = mem_valid && exp_mem_rdy();
        c = alu_valid && mem_valid && q.size() < 4;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (m_rw) begin m_rf[m_wr] = m_wd; m_written[m_wr] = 1'b1; end
            if (wb_enable && q.size() > 0) begin {m_wr, m_wd} = q.pop_front(); m_rw = 1; end
            else m_rw = 0;
            if (a) q.push_back({alu_reg, alu_data});
            else if (m) q.push_back({mem_reg, mem_data});
            if (c) m_alu_turn = !m_alu_turn;
            g_alu = a; g_mem = m;
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h want 00", pending); end
        n_checks++; if ({write_reg, write_data} !== 19'd0) begin n_fail++; $display("FAIL reset_wb_regs got %0d/%h want 0/0000", write_reg, write_data); end
        n_checks++; if ({alu_ready, mem_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b want 11", {alu_ready, mem_ready}); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        alu_valid = 1; alu_reg = 3'd0; alu_data = 16'h1234; wb_enable = 1; #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 0; #1;
        n_checks++; if ({reg_write, fifo_count, pending} !== {1'b0, 3'd1, 8'h01}) begin n_fail++; $display("FAIL single_n0 got rw=%b cnt=%0d pend=%h want 0/1/01", reg_write, fifo_count, pending); end
        tick();
        n_checks++; if ({reg_write, write_reg, write_data, pending} !== {1'b1, 3'd0, 16'h1234, 8'h01}) begin n_fail++; $display("FAIL single_n1 got rw=%b reg=%0d data=%h pend=%h want 1/0/1234/01", reg_write, write_reg, write_data, pending); end
        tick();
        raddr1 = 3'd0; #1;
        n_checks++; if ({reg_write, pending} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL single_n2 got rw=%b pend=%h want 0/00", reg_write, pending); end
        n_checks++; if (read_data1 !== 16'h1234) begin n_fail++; $display("FAIL single_rf got %h want 1234", read_data1); end
    endtask

    task automatic test_conflict();
        alu_valid = 1; alu_reg = 3'd1; alu_data = 16'h5678;
        mem_valid = 1; mem_reg = 3'd2; mem_data = 16'h9ABC; #1;
        n_checks++; if ({mem_ready, alu_ready} !== 2'b10) begin n_fail++; $display("FAIL conflict_first got mem/alu=%b want 10", {mem_ready, alu_ready}); end
        tick();
        mem_valid = 0; #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL conflict_second got %b want 1", alu_ready); end
        tick();
        alu_valid = 0; #1;
        n_checks++; if ({reg_write, write_reg, write_data} !== {1'b1, 3'd2, 16'h9ABC}) begin n_fail++; $display("FAIL conflict_wr1 got %b/%0d/%h want 1/2/9abc", reg_write, write_reg, write_data); end
        tick();
        n_checks++; if ({reg_write, write_reg, write_data} !== {1'b1, 3'd1, 16'h5678}) begin n_fail++; $display("FAIL conflict_wr2 got %b/%0d/%h want 1/1/5678", reg_write, write_reg, write_data); end
        tick();
        raddr1 = 3'd2; #1;
        n_checks++; if (read_data1 !== 16'h9ABC) begin n_fail++; $display("FAIL conflict_rf2 got %h want 9abc", read_data1); end
        raddr1 = 3'd1; #1;
        n_checks++; if (read_data1 !== 16'h5678) begin n_fail++; $display("FAIL conflict_rf1 got %h want 5678", read_data1); end
    endtask

    task automatic test_full();
        logic [2:0] seq[$];
        wb_enable = 0;
        for (int i = 1; i <= 5; i++) begin
            alu_valid = 1; alu_reg = 3'(i); alu_data = 16'h1000 + 16'(i); #1;
            if (i == 5) begin
                n_checks++; if ({alu_ready, mem_ready, fifo_count, pending} !== {2'b00, 3'd4, 8'h1E}) begin n_fail++; $display("FAIL full_state got rdy=%b cnt=%0d pend=%h want 00/4/1e", {alu_ready, mem_ready}, fifo_count, pending); end
            end else begin
                n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL full_accept%0d got %b want 1", i, alu_ready); end
            end
            tick();
        end
        wb_enable = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (g_alu) alu_valid = 0;
            if (reg_write) seq.push_back(write_reg);
            n_checks++; if (fifo_count > 3'd4) begin n_fail++; $display("FAIL full_bound got %0d want <=4", fifo_count); end
        end
        n_checks++; if (seq.size() != 5) begin n_fail++; $display("FAIL full_drain_len got %0d want 5", seq.size()); end
        for (int k = 0; k < seq.size() && k < 5; k++) begin
            n_checks++; if (seq[k] !== 3'(k + 1)) begin n_fail++; $display("FAIL full_order[%0d] got %0d want %0d", k, seq[k], k + 1); end
        end
    endtask

    task automatic test_same_reg();
        alu_valid = 1; alu_reg = 3'd3; alu_data = 16'h0001; #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL same_alu_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 0; mem_valid = 1; mem_reg = 3'd3; mem_data = 16'h0002; #1;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL same_mem_ready got %b want 1", mem_ready); end
        tick();
        mem_valid = 0;
        repeat (3) tick();
        raddr1 = 3'd3; #1;
        n_checks++; if (read_data1 !== 16'h0002) begin n_fail++; $display("FAIL same_reg_final got %h want 0002", read_data1); end
    endtask

    task automatic test_reset_mid();
        wb_enable = 0;
        for (int i = 5; i <= 7; i++) begin
            alu_valid = 1; alu_reg = 3'(i); alu_data = 16'hA5A0 + 16'(i); tick();
        end
        alu_valid = 0; wb_enable = 1;
        tick();
        n_checks++; if ({reg_write, fifo_count} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL mid_before got rw=%b cnt=%0d want 1/2", reg_write, fifo_count); end
        rst_n = 0; model_reset(); #1;
        n_checks++; if ({reg_write, fifo_count, pending} !== {1'b0, 3'd0, 8'h00}) begin n_fail++; $display("FAIL mid_reset got rw=%b cnt=%0d pend=%h want 0/0/00", reg_write, fifo_count, pending); end
        n_checks++; if ({write_reg, write_data} !== 19'd0) begin n_fail++; $display("FAIL mid_wb_regs got %0d/%h want 0/0000", write_reg, write_data); end
        tick();
        rst_n = 1;
        repeat (2) tick();
        raddr1 = 3'd5; #1;
        n_checks++; if ({reg_write, read_data1} !== {1'b0, 16'h1005}) begin n_fail++; $display("FAIL mid_no_write got rw=%b rf5=%h want 0/1005", reg_write, read_data1); end
    endtask

    task automatic test_alternate();
        wb_enable = 1;
        for (int k = 0; k < 8; k++) begin
            alu_valid = 1; mem_valid = 1;
            alu_reg = 3'($urandom); alu_data = 16'($urandom);
            mem_reg = 3'($urandom); mem_data = 16'($urandom); #1;
            n_checks++; if ({mem_ready, alu_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_grant%0d got mem/alu=%b want %s", k, {mem_ready, alu_ready}, (k % 2 == 0) ? "mem" : "alu"); end
            tick();
            n_checks++; if (fifo_count > 3'd4) begin n_fail++; $display("FAIL alt_bound got %0d want <=4", fifo_count); end
        end
        alu_valid = 0; mem_valid = 0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            alu_valid = 1'($urandom); mem_valid = 1'($urandom);
            alu_reg = 3'($urandom); alu_data = 16'($urandom);
            mem_reg = 3'($urandom); mem_data = 16'($urandom);
            wb_enable = ($urandom_range(0, 2) != 0); #1;
            n_checks++; if ({alu_ready, mem_ready} !== {exp_alu_rdy(), exp_mem_rdy()}) begin n_fail++; $display("FAIL rnd_ready%0d got %b want %b", k, {alu_ready, mem_ready}, {exp_alu_rdy(), exp_mem_rdy()}); end
            n_checks++; if (fifo_count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count%0d got %0d want %0d", k, fifo_count, q.size()); end
            n_checks++; if (pending !== exp_pending()) begin n_fail++; $display("FAIL rnd_pending%0d got %h want %h", k, pending, exp_pending()); end
            n_checks++; if ({reg_write, write_reg, write_data} !== {m_rw, m_wr, m_wd}) begin n_fail++; $display("FAIL rnd_out%0d got %b/%0d/%h want %b/%0d/%h", k, reg_write, write_reg, write_data, m_rw, m_wr, m_wd); end
            tick();
        end
        alu_valid = 0; mem_valid = 0; wb_enable = 1;
        repeat (6) tick();
        for (int r = 0; r < 8; r++) begin
            if (m_written[r]) begin
                raddr1 = 3'(r); #1;
                n_checks++; if (read_data1 !== m_rf[r]) begin n_fail++; $display("FAIL rnd_rf%0d got %h want %h", r, read_data1, m_rf[r]); end
            end
        end
    endtask

    initial begin
        alu_valid = 0; mem_valid = 0; wb_enable = 0;
        alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0; raddr1 = 0;
        m_written = '0;
        model_reset();
        test_reset();
        test_single();
        test_conflict();
        test_full();
        test_same_reg();
        test_reset_mid();
        test_alternate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock shared with RegisterFile
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this edge when alu_valid=1
- alu_reg  in  3  ALU destination register
- alu_data  in  16  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this edge when mem_valid=1
- mem_reg  in  3  load destination register
- mem_data  in  16  load result
- wb_enable  in  1  1 = RegisterFile write port free for this block
- write_reg  out  3  to RegisterFile write_reg
- write_data  out  16  to RegisterFile write_data
- reg_write  out  1  to RegisterFile reg_write
- pending  out  8  bit r = write to register r queued or on the output
- fifo_count  out  3  queued entries, 0..4

Function
REQ-003 A source transfer SHALL occur at a rising clk edge when its valid and ready are both 1.
REQ-004 Accepted results SHALL enter a 4-entry in-order FIFO of {reg[2:0], data[15:0]}.
REQ-005 alu_ready and mem_ready SHALL be 0 whenever fifo_count=4; pushes SHALL NOT pass through a same-cycle pop.
REQ-006 At most one source SHALL be accepted per edge; when both valid and not full, a round-robin flag SHALL pick the source not granted at the last conflict; after reset mem wins first.
REQ-007 With only one source valid and not full, that source's ready SHALL be 1, regardless of the flag; the flag SHALL change only on conflicts.
REQ-008 Each ready SHALL be combinational from fifo_count, the other source's valid and the flag, and SHALL NOT depend on its own valid.
REQ-009 Each edge with wb_enable=1 and fifo_count>0 SHALL pop the head into registered write_reg/write_data and set reg_write=1 for the following cycle.
REQ-010 Each edge without a pop SHALL clear reg_write; write_reg/write_data SHALL hold their last values.
REQ-011 Minimum latency: accept at edge N, reg_write=1 after edge N+1, RegisterFile captures at edge N+2.
REQ-012 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo 4.
REQ-013 pending[r] SHALL be the OR over valid FIFO entries with reg=r and (reg_write=1 and write_reg=r), computed combinationally.
REQ-014 Register 0 SHALL be an ordinary writable destination with no special-casing.
REQ-015 Back-to-back results to the same register SHALL reach the RegisterFile in acceptance order.
REQ-016 wb_enable=0 SHALL stall draining only; acceptance SHALL continue until full.

Reset
REQ-017 rst_n=0 SHALL immediately clear the FIFO, fifo_count=0, pending=0, reg_write=0, write_reg=0, write_data=0, flag=mem-first.
REQ-018 Reset mid-operation SHALL discard queued results without emitting any RegisterFile write.
REQ-019 After rst_n deasserts, acceptance SHALL resume at the next edge.

Structure
REQ-020 Package reg_pkg SHALL hold REG_ADDR_W=3, DATA_W=16, NUM_REGS=8, WB_FIFO_DEPTH=4 and the FIFO entry typedef.
REQ-021 The FIFO SHALL be the sub-module wb_fifo (push, pop, head, count, per-entry valid/reg), with arbitration and output registers in reg_writeback.

Verification
REQ-022 Bench SHALL drive reg_writeback into a real RegisterFile and cover:
- alu 3'd0/16'h1234 single, wb_enable=1 -> reg_write at N+1, read_data1 of reg0=16'h1234 after N+2; pending[0] 1 for two cycles.
- alu 3'd1/16'h5678 and mem 3'd2/16'h9ABC both valid -> mem accepted first, alu next edge; writes occur in that order.
- wb_enable=0, five alu pushes to regs 1..5 -> four accepted, alu_ready=0, fifo_count=4, pending=8'h1E; wb_enable=1 -> drains regs 1..4, then reg5.
- alu reg3=16'h0001 then mem reg3=16'h0002 -> reg3 reads 16'h0002 at end.
- 3 entries queued, rst_n pulsed low -> reg_write=0 immediately, fifo_count=0, pending=0, no RegisterFile write.
- sustained conflicts, 8 cycles -> grants alternate mem, alu, mem, ...; fifo_count never exceeds 4.
